// File: rtl/psum_drain.sv
// Drains finished stage sums: capture, round-shift, saturate, optional ReLU, then a small output FIFO.
// Latency: capture in cycle N is visible on out_valid in N+2; when full and not popping, new words are dropped.
module psum_drain #(
  parameter int SUM_BIT_WIDTH = 24,
  parameter int OUT_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     layer_reset,
  input  logic                     stage_finish,
  input  logic                     layer_last,
  input  logic [SUM_BIT_WIDTH-1:0] sum,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [OUT_BIT_WIDTH-1:0] out_data,
  output logic                     sat_flag,
  output logic                     overrun_flag
);

  localparam int EW = SUM_BIT_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [EW-1:0] OUT_MAX =
    {{(EW-OUT_BIT_WIDTH+1){1'b0}}, {(OUT_BIT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN =
    {{(EW-OUT_BIT_WIDTH+1){1'b1}}, {(OUT_BIT_WIDTH-1){1'b0}}};

  typedef enum logic {WAIT_FIRST, RUN} state_t;

  state_t                   state_q;
  logic                     cap_vld_q;
  logic [SUM_BIT_WIDTH-1:0] cap_val_q;
  logic [OUT_BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     sat_q, ovr_q;

  logic                     capture;
  logic signed [EW-1:0]     ext, rnd_inc, shifted;
  logic [OUT_BIT_WIDTH-1:0] res_d;
  logic                     res_sat_d;
  logic                     fifo_full, pop, push, drop;

  // The first stage_finish after reset carries only the accumulator's init value.
  assign capture = layer_last | (stage_finish & (state_q == RUN));

  always_ff @(posedge clk) begin
    if (layer_reset) begin
      state_q   <= WAIT_FIRST;
      cap_vld_q <= 1'b0;
      cap_val_q <= '0;
    end else begin
      cap_vld_q <= capture;
      if (capture) cap_val_q <= sum;
      if (layer_last) state_q <= WAIT_FIRST;
      else if (stage_finish) state_q <= RUN;
    end
  end

  always_comb begin
    ext       = {cap_val_q[SUM_BIT_WIDTH-1], cap_val_q};
    rnd_inc   = {{(EW-1){1'b0}}, 1'b1} << (shift - 5'd1);
    shifted   = (shift == 5'd0) ? ext : ($signed(ext + rnd_inc) >>> shift);
    res_d     = shifted[OUT_BIT_WIDTH-1:0];
    res_sat_d = 1'b0;
    if (shifted > OUT_MAX) begin
      res_d     = OUT_MAX[OUT_BIT_WIDTH-1:0];
      res_sat_d = 1'b1;
    end else if (shifted < OUT_MIN) begin
      res_d     = OUT_MIN[OUT_BIT_WIDTH-1:0];
      res_sat_d = 1'b1;
    end
    // ReLU acts after saturation and never counts as a saturation event.
    if (relu_en && res_d[OUT_BIT_WIDTH-1]) res_d = '0;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = cap_vld_q & (~fifo_full | pop);
  assign drop      = cap_vld_q & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_d;
  end

  always_ff @(posedge clk) begin
    if (layer_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (cap_vld_q && res_sat_d) sat_q <= 1'b1;
      if (drop) ovr_q <= 1'b1;
    end
  end

  assign sat_flag     = sat_q;
  assign overrun_flag = ovr_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed test-plan steps followed by a randomized phase, all checked against a queue-based reference model.
module tb_psum_drain;

  logic        clk = 1'b0;
  logic        rst, sf, ll, re, rdy;
  logic [23:0] sm;
  logic [4:0]  sh;
  logic        out_valid, sat_flag, overrun_flag;
  logic [15:0] out_data;

  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_run, m_pend, m_sat, m_ovr;
  logic [23:0] m_pend_sum;
  logic [15:0] m_q[$];

  psum_drain dut (
    .clk(clk), .layer_reset(rst), .stage_finish(sf), .layer_last(ll),
    .sum(sm), .shift(sh), .relu_en(re), .out_ready(rdy),
    .out_valid(out_valid), .out_data(out_data),
    .sat_flag(sat_flag), .overrun_flag(overrun_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [23:0] s, input int shv,
                                           input bit relu, output bit sat);
    longint v;
    v   = longint'($signed(s));
    sat = 1'b0;
    if (shv > 0) v = (v + (longint'(1) << (shv - 1))) >>> shv;
    if (v > 32767)       begin v = 32767;  sat = 1'b1; end
    else if (v < -32768) begin v = -32768; sat = 1'b1; end
    if (relu && v < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic model_edge();
    bit pop, full, s;
    logic [15:0] w;
    if (rst) begin
      m_run = 0; m_pend = 0; m_sat = 0; m_ovr = 0;
      m_q.delete();
      return;
    end
    full = (m_q.size() == 4);
    pop  = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (m_pend) begin
      w = ref_word(m_pend_sum, int'(sh), re, s);
      if (s) m_sat = 1;
      if (!full || pop) m_q.push_back(w);
      else m_ovr = 1;
    end
    m_pend     = ll || (m_run && sf);
    m_pend_sum = sm;
    if (ll) m_run = 0;
    else if (sf) m_run = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("data", 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("sat", 32'(sat_flag), 32'(m_sat));
    chk("ovr", 32'(overrun_flag), 32'(m_ovr));
  endtask

  task automatic idle();
    sf = 0; ll = 0;
    step();
  endtask

  task automatic capture(input logic [23:0] v);
    sf = 1; ll = 0; sm = v;
    step();
    sf = 0;
  endtask

  task automatic do_reset();
    rst = 1; sf = 0; ll = 0; rdy = 0;
    step();
    rst = 0;
  endtask

  // Capture, wait for the word to reach the head, check it, then pop it.
  task automatic cap_check(input string tag, input logic [23:0] v, input logic [15:0] exp);
    rdy = 0;
    capture(v);
    idle();
    chk(tag, 32'(out_data), 32'(exp));
    rdy = 1;
    idle();
    rdy = 0;
  endtask

  initial begin
    rst = 1; sf = 0; ll = 0; sm = '0; sh = 5'd0; re = 0; rdy = 0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_ovr", 32'(overrun_flag), 32'd0);
    rst = 0;

    // First-pulse skip
    idle();
    capture(24'h000123);
    idle();
    idle();
    chk("skip_first", 32'(out_valid), 32'd0);
    capture(24'h000100);
    chk("lat_n1", 32'(out_valid), 32'd0);
    idle();
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("lat_n2_data", 32'(out_data), 32'h0100);
    rdy = 1; idle(); rdy = 0;

    // Rounding, ReLU, saturation
    sh = 5'd4;
    cap_check("round_pos", 24'h000018, 16'h0002);
    cap_check("round_neg", 24'hFFFFE8, 16'hFFFF);
    re = 1;
    cap_check("relu_neg", 24'hFFFFE8, 16'h0000);
    chk("relu_no_sat", 32'(sat_flag), 32'd0);
    re = 0; sh = 5'd0;
    cap_check("sat_pos", 24'h7FFFFF, 16'h7FFF);
    chk("sat_flag", 32'(sat_flag), 32'd1);

    // Backpressure and overrun
    rdy = 0;
    for (int i = 1; i <= 5; i++) capture(24'(i));
    idle();
    idle();
    chk("ovr_flag", 32'(overrun_flag), 32'd1);
    rdy = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(out_data), 32'(i));
      idle();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Full with simultaneous pop
    do_reset();
    capture(24'h0);
    rdy = 0;
    for (int i = 10; i <= 13; i++) capture(24'(i));
    idle();
    idle();
    capture(24'd14);
    rdy = 1;
    idle();
    chk("full_pop_no_ovr", 32'(overrun_flag), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("full_pop_order", 32'(out_data), 32'(i));
      idle();
    end
    chk("full_pop_empty", 32'(out_valid), 32'd0);

    // Layer end with coincident stage_finish
    rdy = 0;
    do_reset();
    capture(24'h0);
    sf = 1; ll = 1; sm = 24'h000040;
    step();
    ll = 0; sf = 0;
    idle();
    chk("last_word", 32'(out_data), 32'h0040);
    rdy = 1; idle(); rdy = 0;
    chk("last_single", 32'(out_valid), 32'd0);
    capture(24'h000055);
    idle(); idle(); idle();
    chk("last_then_skip", 32'(out_valid), 32'd0);

    // Mid-operation reset with buffered words and one in flight
    capture(24'h000021);
    capture(24'h7FFFFF);
    capture(24'h000023);
    capture(24'h000024);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_sat", 32'(sat_flag), 32'd0);
    chk("mrst_ovr", 32'(overrun_flag), 32'd0);
    rdy = 1;
    for (int i = 0; i < 6; i++) idle();
    chk("mrst_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (rst) begin
        sh = 5'($urandom_range(0, 23));
        re = 1'($urandom_range(0, 1));
      end
      sf  = ($urandom_range(0, 99) < 55);
      ll  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 45);
      sm  = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 4095)) : 24'($urandom());
      step();
    end
    rst = 0; sf = 0; ll = 0;

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
